systolic_row_feeder: RTL and testbench

Upstream feeder for the systolic PE array. It buffers activation vectors (one MUL_BW element per array row) in a small FIFO and applies the diagonal skew the array needs: row r is delayed r cycles relative to row 0. It drives each row's left-edge `i_left` input, and after the last vector of a tile it flushes zeros so the wavefront fully drains.

---
 rtl/systolic_row_feeder.sv | 208 ++++++++++++++++++++
 tb/tb_systolic_row_feeder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_row_feeder.sv
// systolic_row_feeder
// Buffers activation vectors (one MUL_BW element per array row) in a small
// registered FIFO and applies the diagonal skew the systolic array needs:
// lane r is delayed r cycles relative to lane 0. After the last vector of a
// tile it injects zeros until that vector has reached lane ROWS-1, so the
// wavefront fully drains before the next tile enters.
//
// Ports:
//   clk, rst       single rising-edge clock, synchronous active-high reset
//   i_valid/o_ready/i_data/i_last
//                  input vector handshake. A vector (with its last flag) is
//                  accepted on every rising edge where i_valid && o_ready;
//                  i_valid may be held regardless of o_ready, and data is
//                  only consumed on an accepting edge. o_ready = !full && !rst.
//   i_en           array advance enable; when low the skew chains, FSM and
//                  flush counter hold (pushes still proceed)
//   o_left         per-lane value to PE row r i_left, lane r at [r*MUL_BW +: MUL_BW]
//   o_lane_valid   lane r carries real data (not a bubble / flush zero)
//   o_busy         FSM not idle or any lane valid
//   o_done         one-cycle pulse when a tile's last element reaches lane ROWS-1
//   o_dbg_state    current FSM state (IDLE=0, STREAM=1, FLUSH=2)
module systolic_row_feeder #(
    parameter int MUL_BW = 16,
    parameter int ROWS   = 4,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [ROWS*MUL_BW-1:0] i_data,
    input  logic                   i_last,
    output logic                   o_ready,
    input  logic                   i_en,
    output logic [ROWS*MUL_BW-1:0] o_left,
    output logic [ROWS-1:0]        o_lane_valid,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [1:0]             o_dbg_state
);

    localparam int VW    = ROWS * MUL_BW;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int FC_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // ---------------- FIFO ----------------
    // Each entry is {last, data}.
    logic [VW:0]      mem_q [DEPTH];
    logic [VW:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full, empty, push, pop;
    logic [VW-1:0] head_data;
    logic          head_last;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign o_ready   = !full && !rst;
    assign push      = i_valid && o_ready;
    assign head_data = mem_q[rd_ptr_q][VW-1:0];
    assign head_last = mem_q[rd_ptr_q][VW];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {i_last, i_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: reads only happen when count_q says an entry is live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ---------------- FSM ----------------
    state_e          state_q, state_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    logic            done_q, done_d;
    logic [FC_W-1:0] flush_cnt_inc;

    assign flush_cnt_inc = flush_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pop         = 1'b0;
        // o_done is a single-cycle pulse even when the array is stalled.
        done_d      = 1'b0;
        if (i_en) begin
            case (state_q)
                ST_IDLE, ST_STREAM: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_STREAM;
                        if (head_last) begin
                            if (ROWS > 1) begin
                                state_d     = ST_FLUSH;
                                flush_cnt_d = '0;
                            end else begin
                                // Single lane: the element is already at the last lane.
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    flush_cnt_d = flush_cnt_inc;
                    // ROWS-1 zero injections after the last pop put the last
                    // element on lane ROWS-1 exactly at this edge.
                    if (flush_cnt_inc == FC_W'(ROWS - 1)) begin
                        done_d  = 1'b1;
                        state_d = empty ? ST_IDLE : ST_STREAM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= done_d;
        end
    end

    // ---------------- Skew chains ----------------
    // Injected column: the popped vector, or zeros (bubble / flush).
    logic [VW-1:0] inj_data;
    assign inj_data = pop ? head_data : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [MUL_BW-1:0] data_q [0:r];
        logic [MUL_BW-1:0] data_d [0:r];
        logic [r:0]        vld_q, vld_d;

        always_comb begin
            data_d = data_q;
            vld_d  = vld_q;
            if (i_en) begin
                data_d[0] = inj_data[r*MUL_BW +: MUL_BW];
                vld_d[0]  = pop;
                for (int s = 1; s <= r; s++) begin
                    data_d[s] = data_q[s-1];
                    vld_d[s]  = vld_q[s-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s <= r; s++) begin
                    data_q[s] <= '0;
                end
                vld_q <= '0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end

        assign o_left[r*MUL_BW +: MUL_BW] = data_q[r];
        assign o_lane_valid[r]            = vld_q[r];
    end

    assign o_busy      = (state_q != ST_IDLE) || (|o_lane_valid);
    assign o_done      = done_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Testbench for systolic_row_feeder (ROWS=4, DEPTH=4, MUL_BW=16).
// Directed steps plus a randomized phase, every cycle compared against a
// reference model: a queue of buffered vectors and a short history of the
// columns injected on enabled edges. Lane r shows the column injected r
// enabled edges ago; a tile's last vector blocks further pops for ROWS-1
// enabled edges so the wavefront drains.
module tb_systolic_row_feeder;
    localparam int MUL_BW = 16;
    localparam int ROWS   = 4;
    localparam int DEPTH  = 4;
    localparam int W      = ROWS * MUL_BW;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [W-1:0]  i_data;
    logic          i_last;
    logic          i_en;
    logic          o_ready;
    logic [W-1:0]  o_left;
    logic [ROWS-1:0] o_lane_valid;
    logic          o_busy;
    logic          o_done;
    logic [1:0]    o_dbg_state;

    always #5 clk = ~clk;

    systolic_row_feeder #(.MUL_BW(MUL_BW), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_last       (i_last),
        .o_ready      (o_ready),
        .i_en         (i_en),
        .o_left       (o_left),
        .o_lane_valid (o_lane_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_dbg_state  (o_dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [W:0]   fifo_m [$];   // {last, data}
    logic [W-1:0] hist_d [$];   // injected columns, oldest first
    bit           hist_v [$];
    bit           hist_l [$];
    int           flush_left = 0;
    bit           in_tile    = 1'b0;
    bit           done_m     = 1'b0;

    function automatic logic [W-1:0] exp_left();
        logic [W-1:0] v;
        int idx;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            idx = hist_d.size() - 1 - r;
            if (idx >= 0 && hist_v[idx]) v[r*MUL_BW +: MUL_BW] = hist_d[idx][r*MUL_BW +: MUL_BW];
        end
        return v;
    endfunction

    function automatic logic [ROWS-1:0] exp_valid();
        logic [ROWS-1:0] v;
        int idx;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            idx = hist_d.size() - 1 - r;
            if (idx >= 0) v[r] = hist_v[idx];
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge from the pre-edge inputs, then compare all outputs.
    task automatic tick();
        bit           push;
        logic [W:0]   head;
        logic [W-1:0] inj_d;
        bit           inj_v;
        bit           inj_l;
        push = i_valid && (fifo_m.size() < DEPTH) && !rst;
        @(posedge clk);
        done_m = 1'b0;
        if (rst) begin
            fifo_m.delete();
            hist_d.delete();
            hist_v.delete();
            hist_l.delete();
            flush_left = 0;
            in_tile    = 1'b0;
        end else begin
            if (i_en) begin
                inj_d = '0;
                inj_v = 1'b0;
                inj_l = 1'b0;
                if (flush_left > 0) begin
                    flush_left--;
                    if (flush_left == 0) in_tile = (fifo_m.size() > 0);
                end else if (fifo_m.size() > 0) begin
                    head  = fifo_m.pop_front();
                    inj_d = head[W-1:0];
                    inj_v = 1'b1;
                    inj_l = head[W];
                    if (inj_l) begin
                        in_tile    = 1'b0;
                        flush_left = ROWS - 1;
                    end else begin
                        in_tile = 1'b1;
                    end
                end
                hist_d.push_back(inj_d);
                hist_v.push_back(inj_v);
                hist_l.push_back(inj_l);
                if (hist_d.size() > ROWS) begin
                    void'(hist_d.pop_front());
                    void'(hist_v.pop_front());
                    void'(hist_l.pop_front());
                end
                if (hist_d.size() == ROWS && hist_v[0] && hist_l[0]) done_m = 1'b1;
            end
            if (push) fifo_m.push_back({i_last, i_data});
        end
        #1;
        check("o_left", o_left, exp_left());
        check("o_lane_valid", W'(o_lane_valid), W'(exp_valid()));
        check("o_done", W'(o_done), W'(done_m));
        check("o_busy", W'(o_busy), W'(in_tile || (flush_left > 0) || (|exp_valid())));
        check("o_ready", W'(o_ready), W'((fifo_m.size() < DEPTH) && !rst));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input logic [W-1:0] d, input bit l, input bit en);
        i_valid = v;
        i_data  = d;
        i_last  = l;
        i_en    = en;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*MUL_BW +: MUL_BW] = MUL_BW'($urandom);
        return v;
    endfunction

    logic [W-1:0] vec;

    initial begin
        // ---- reset with i_valid high: nothing accepted ----
        rst = 1'b1;
        drive(1'b1, rand_vec(), 1'b1, 1'b1);
        drive(1'b1, rand_vec(), 1'b0, 1'b1);
        check("rst_o_ready", W'(o_ready), W'(0));
        check("rst_o_left", o_left, '0);
        check("rst_state_idle", W'(o_dbg_state), W'(0));
        rst = 1'b0;
        i_valid = 1'b0;
        #1;
        check("post_rst_ready", W'(o_ready), W'(1));
        check("post_rst_busy", W'(o_busy), W'(0));

        // ---- single vector, diagonal timing ----
        vec = 64'h0004_0003_0002_0001;
        drive(1'b1, vec, 1'b1, 1'b1);              // accepted at edge k
        drive(1'b0, '0, 1'b0, 1'b1);               // k+1
        check("sv_lane0", o_left, 64'h0000_0000_0000_0001);
        check("sv_valid0", W'(o_lane_valid), W'(4'b0001));
        idle(1);                                   // k+2
        check("sv_lane1", o_left, 64'h0000_0000_0002_0000);
        idle(1);                                   // k+3
        check("sv_lane2", o_left, 64'h0000_0003_0000_0000);
        idle(1);                                   // k+4
        check("sv_lane3", o_left, 64'h0004_0000_0000_0000);
        check("sv_done", W'(o_done), W'(1));
        idle(1);
        check("sv_done_clear", W'(o_done), W'(0));
        check("sv_idle", W'(o_busy), W'(0));

        // ---- back-to-back tile of three ----
        drive(1'b1, {4{16'h0011}}, 1'b0, 1'b1);
        drive(1'b1, {4{16'h0022}}, 1'b0, 1'b1);
        drive(1'b1, {4{16'h0033}}, 1'b1, 1'b1);
        idle(9);

        // ---- FIFO full with array stalled ----
        drive(1'b1, rand_vec(), 1'b0, 1'b0);
        drive(1'b1, rand_vec(), 1'b0, 1'b0);
        drive(1'b1, rand_vec(), 1'b0, 1'b0);
        drive(1'b1, rand_vec(), 1'b1, 1'b0);
        check("full_ready_low", W'(o_ready), W'(0));
        vec = rand_vec();
        drive(1'b1, vec, 1'b1, 1'b0);              // refused
        drive(1'b1, vec, 1'b1, 1'b1);              // first pop
        check("full_ready_rise", W'(o_ready), W'(1));
        drive(1'b1, vec, 1'b1, 1'b1);              // 5th accepted
        idle(24);

        // ---- stall mid-wavefront ----
        drive(1'b1, rand_vec(), 1'b0, 1'b1);
        drive(1'b1, rand_vec(), 1'b0, 1'b1);
        drive(1'b1, rand_vec(), 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b0);
        idle(8);

        // ---- reset during flush ----
        drive(1'b1, rand_vec(), 1'b1, 1'b1);       // push
        idle(1);                                   // last pop
        idle(2);
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b1);
        check("rstf_left", o_left, '0);
        check("rstf_valid", W'(o_lane_valid), W'(0));
        check("rstf_done", W'(o_done), W'(0));
        check("rstf_busy", W'(o_busy), W'(0));
        rst = 1'b0;
        idle(6);

        // ---- randomized traffic ----
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 6, rand_vec(), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) < 8);
        end
        rst = 1'b0;
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
